// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Stall/flush controller for the 5-stage MIPS pipeline: load-use
//            detection, mult/div busy tracking, PC/IF-ID gating, ID/EX bubbles.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             uses_rs_id,
    input  logic             uses_rt_id,
    input  logic             memread_ex,
    input  logic [4:0]       wreg_ex,
    input  logic             branch_taken_id,
    input  logic             md_start_id,
    input  logic             hilo_read_id,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    localparam logic [3:0]       c_md_latency     = 4'(MD_LATENCY);
    localparam logic             c_flush_on_taken = (DELAY_SLOT == 0);
    localparam logic [CNT_W-1:0] c_cnt_one        = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [3:0]       r_md_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_busy;
    logic w_load_use;
    logic w_md_haz;
    logic w_stall;

    assign w_busy = (r_state == ST_MD_BUSY);

    // $0 is hardwired, so a load targeting it can never feed a consumer.
    assign w_load_use = memread_ex && (wreg_ex != 5'd0) &&
                        ((uses_rs_id && (rs_id == wreg_ex)) ||
                         (uses_rt_id && (rt_id == wreg_ex)));
    assign w_md_haz   = w_busy && (hilo_read_id || md_start_id);
    assign w_stall    = w_load_use || w_md_haz;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_md_cnt    <= 4'd0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (md_start_id && !w_stall) begin
                        r_state  <= ST_MD_BUSY;
                        r_md_cnt <= c_md_latency;
                    end
                end
                ST_MD_BUSY: begin
                    // A start seen in the last busy cycle is stalled and
                    // launches from RUN on the following cycle.
                    r_md_cnt <= r_md_cnt - 4'd1;
                    if (r_md_cnt == 4'd1) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_md_cnt <= 4'd0;
                end
            endcase

            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
        end
    end

    // Stall outranks a taken branch: its operands may still be stale.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (reset) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_stall) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            ifid_flush  = branch_taken_id && c_flush_on_taken;
        end
    end

    assign md_busy   = w_busy && !reset;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Scoreboard bench; three parameterisations share one stimulus
//            stream and are checked against a countdown/arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int c_n = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_id, rt_id, wreg_ex;
    logic       uses_rs_id, uses_rt_id, memread_ex;
    logic       branch_taken_id, md_start_id, hilo_read_id;

    logic        pc_we_a, ifid_we_a, ifid_flush_a, idex_bubble_a, md_busy_a;
    logic        pc_we_b, ifid_we_b, ifid_flush_b, idex_bubble_b, md_busy_b;
    logic        pc_we_c, ifid_we_c, ifid_flush_c, idex_bubble_c, md_busy_c;
    logic [15:0] stall_cnt_a;
    logic [3:0]  stall_cnt_b;
    logic [7:0]  stall_cnt_c;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MD_LATENCY(4), .DELAY_SLOT(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id),
        .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id), .memread_ex(memread_ex),
        .wreg_ex(wreg_ex), .branch_taken_id(branch_taken_id), .md_start_id(md_start_id),
        .hilo_read_id(hilo_read_id), .pc_we(pc_we_a), .ifid_we(ifid_we_a),
        .ifid_flush(ifid_flush_a), .idex_bubble(idex_bubble_a), .md_busy(md_busy_a),
        .stall_cnt(stall_cnt_a)
    );

    pipeline_hazard_ctrl #(.MD_LATENCY(2), .DELAY_SLOT(0), .CNT_W(4)) u_dut_b (
        .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id),
        .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id), .memread_ex(memread_ex),
        .wreg_ex(wreg_ex), .branch_taken_id(branch_taken_id), .md_start_id(md_start_id),
        .hilo_read_id(hilo_read_id), .pc_we(pc_we_b), .ifid_we(ifid_we_b),
        .ifid_flush(ifid_flush_b), .idex_bubble(idex_bubble_b), .md_busy(md_busy_b),
        .stall_cnt(stall_cnt_b)
    );

    pipeline_hazard_ctrl #(.MD_LATENCY(15), .DELAY_SLOT(0), .CNT_W(8)) u_dut_c (
        .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id),
        .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id), .memread_ex(memread_ex),
        .wreg_ex(wreg_ex), .branch_taken_id(branch_taken_id), .md_start_id(md_start_id),
        .hilo_read_id(hilo_read_id), .pc_we(pc_we_c), .ifid_we(ifid_we_c),
        .ifid_flush(ifid_flush_c), .idex_bubble(idex_bubble_c), .md_busy(md_busy_c),
        .stall_cnt(stall_cnt_c)
    );

    typedef struct packed {
        logic [1:0]  inst;
        logic        pc_we;
        logic        ifid_we;
        logic        ifid_flush;
        logic        idex_bubble;
        logic        md_busy;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int m_rem [c_n];
    int m_cnt [c_n];

    function automatic int lat_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 2 : 15;
    endfunction

    function automatic int ds_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic int max_of(input int i);
        return (i == 0) ? 65535 : (i == 1) ? 15 : 255;
    endfunction

    function automatic exp_t act_of(input int i);
        exp_t a;
        a.inst = 2'(i);
        case (i)
            0: begin
                a.pc_we = pc_we_a; a.ifid_we = ifid_we_a; a.ifid_flush = ifid_flush_a;
                a.idex_bubble = idex_bubble_a; a.md_busy = md_busy_a; a.cnt = stall_cnt_a;
            end
            1: begin
                a.pc_we = pc_we_b; a.ifid_we = ifid_we_b; a.ifid_flush = ifid_flush_b;
                a.idex_bubble = idex_bubble_b; a.md_busy = md_busy_b;
                a.cnt = {12'd0, stall_cnt_b};
            end
            default: begin
                a.pc_we = pc_we_c; a.ifid_we = ifid_we_c; a.ifid_flush = ifid_flush_c;
                a.idex_bubble = idex_bubble_c; a.md_busy = md_busy_c;
                a.cnt = {8'd0, stall_cnt_c};
            end
        endcase
        return a;
    endfunction

    // Drive one cycle of inputs, predict every instance's outputs, then advance the model.
    task automatic step(input bit r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] wr, input bit urs, input bit urt, input bit mr,
                        input bit br, input bit mds, input bit hilo);
        reset = r; rs_id = rs; rt_id = rt; wreg_ex = wr;
        uses_rs_id = urs; uses_rt_id = urt; memread_ex = mr;
        branch_taken_id = br; md_start_id = mds; hilo_read_id = hilo;
        for (int i = 0; i < c_n; i++) begin
            exp_t e;
            bit   busy, lu, stall;
            busy  = (m_rem[i] > 0);
            lu    = mr && (wr != 0) && ((urs && rs == wr) || (urt && rt == wr));
            stall = lu || (busy && (hilo || mds));
            e.inst = 2'(i);
            e.cnt  = 16'(m_cnt[i]);
            if (r) begin
                e.pc_we = 0; e.ifid_we = 0; e.ifid_flush = 1; e.idex_bubble = 1; e.md_busy = 0;
                m_rem[i] = 0;
                m_cnt[i] = 0;
            end else begin
                e.md_busy     = busy;
                e.pc_we       = !stall;
                e.ifid_we     = !stall;
                e.idex_bubble = stall;
                e.ifid_flush  = !stall && br && (ds_of(i) == 0);
                if (busy) m_rem[i] = m_rem[i] - 1;
                else if (mds && !stall) m_rem[i] = lat_of(i);
                if (stall && m_cnt[i] < max_of(i)) m_cnt[i] = m_cnt[i] + 1;
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit r);
        step(r, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e, a;
            e = exp_q.pop_front();
            a = act_of(int'(e.inst));
            checks++;
            if (a != e) begin
                errors++;
                $display("FAIL outputs inst%0d t=%0t got pc_we=%b ifid_we=%b flush=%b bubble=%b busy=%b cnt=%0d expected pc_we=%b ifid_we=%b flush=%b bubble=%b busy=%b cnt=%0d",
                         e.inst, $time, a.pc_we, a.ifid_we, a.ifid_flush, a.idex_bubble,
                         a.md_busy, a.cnt, e.pc_we, e.ifid_we, e.ifid_flush,
                         e.idex_bubble, e.md_busy, e.cnt);
            end
        end
    end

    initial begin
        for (int i = 0; i < c_n; i++) begin
            m_rem[i] = 0;
            m_cnt[i] = 0;
        end
        reset = 1; rs_id = 0; rt_id = 0; wreg_ex = 0; uses_rs_id = 0; uses_rt_id = 0;
        memread_ex = 0; branch_taken_id = 0; md_start_id = 0; hilo_read_id = 0;
        @(posedge clk);
        #1;

        idle(1); idle(1);
        idle(0);
        // Load-use on rs, then the load has moved on.
        step(0, 5'd5, 5'd7, 5'd5, 1, 1, 1, 0, 0, 0);
        step(0, 5'd5, 5'd7, 5'd9, 1, 1, 0, 0, 0, 0);
        // Load into $0 never stalls.
        step(0, 5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0);
        // mult then a string of mfhi.
        step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0);
        repeat (5) step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1);
        repeat (12) idle(0);
        // Taken branch alone, then with load-use on rt.
        step(0, 5'd1, 5'd2, 5'd0, 1, 1, 0, 1, 0, 0);
        step(0, 5'd1, 5'd2, 5'd2, 1, 1, 1, 1, 0, 0);
        step(0, 5'd1, 5'd2, 5'd0, 1, 1, 0, 1, 0, 0);
        // Reset in the middle of a mult/div, then a HI/LO read.
        step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0);
        idle(0); idle(0);
        idle(1);
        step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1);
        // Continuous hazard to saturate the narrow counters.
        repeat (20) step(0, 5'd3, 5'd0, 5'd3, 1, 0, 1, 0, 0, 0);
        idle(1);

        repeat (2000) begin
            step(($urandom_range(0, 99) < 2),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3);
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain leftover=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Gates PC update and the IF/ID buffer write, flushes IF/ID on taken branches, and inserts bubbles into ID/EX.
- Detects load-use hazards and tracks the multi-cycle mult/div unit so HI/LO readers wait.
- Sits beside the decode stage. Takes register fields from ID and destination info from EX.

Parameters:
- MD_LATENCY, 4, cycles the mult/div unit is busy after a start (1..15).
- DELAY_SLOT, 1, 1 = branch delay slot architected (no IF/ID flush on taken branch); 0 = flush the fetched instruction.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- rs_id  in  5  rs field of the instruction in ID.
- rt_id  in  5  rt field of the instruction in ID.
- uses_rs_id  in  1  ID instruction reads rs.
- uses_rt_id  in  1  ID instruction reads rt.
- memread_ex  in  1  EX instruction is a load.
- wreg_ex  in  5  EX destination register.
- branch_taken_id  in  1  branch/jump resolved taken in ID.
- md_start_id  in  1  ID instruction is mult/multu/div/divu.
- hilo_read_id  in  1  ID instruction is mfhi/mflo (or mthi/mtlo).
- pc_we  out  1  PC may update.
- ifid_we  out  1  IF/ID buffer may capture.
- ifid_flush  out  1  IF/ID buffer loads zero (NOP).
- idex_bubble  out  1  ID/EX control fields forced to NOP.
- md_busy  out  1  mult/div unit busy.
- stall_cnt  out  CNT_W  total stall cycles since reset, saturating.

Behaviour:
Reset
- All of these are sampled at the clk edge; reset is synchronous and active-high.
- Reset clears state to RUN, the md counter to 0 and stall_cnt to 0.
- While reset is high, outputs are forced to: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, md_busy=0.

State machine
- Two states: RUN and MD_BUSY.
- 4-bit md_cnt.
- RUN to MD_BUSY: md_start_id=1 and stall=0. Load md_cnt=MD_LATENCY.
- In MD_BUSY: md_cnt decrements each cycle. Return to RUN when md_cnt==1 on the edge, so busy lasts exactly MD_LATENCY cycles.
- md_busy = (state==MD_BUSY).

Hazard terms (combinational, same cycle)
- load_use = memread_ex & wreg_ex!=0 & ((uses_rs_id & rs_id==wreg_ex) | (uses_rt_id & rt_id==wreg_ex)).
- md_haz = md_busy & (hilo_read_id | md_start_id).
- stall = load_use | md_haz.

Outputs (combinational from state and inputs; zero added latency)
- If stall: pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0.
- Else: pc_we=1, ifid_we=1, idex_bubble=0, ifid_flush = branch_taken_id & (DELAY_SLOT==0).

Priority and boundaries
- Stall beats branch: branch_taken_id is ignored while stall=1, because operands may be stale. It is re-evaluated once the stall clears.
- md_start_id while stall=1 does not start the counter.
- md_start_id in the final busy cycle (md_cnt==1) still stalls. It starts on the following cycle in RUN.
- wreg_ex==0 never causes a load-use stall.
- Load-use lasts exactly 1 cycle, because the load advances to MEM.
- stall_cnt increments on every cycle with stall=1 and reset=0, saturating at all-ones.
- Reset asserted mid-MD_BUSY returns to RUN with md_busy=0 on the next edge.

Test Plan:
- Reset held 2 cycles -> pc_we=0, ifid_flush=1, idex_bubble=1, stall_cnt=0. After release -> pc_we=1, ifid_we=1, bubble=0.
- lw to $5 in EX (memread_ex=1, wreg_ex=5); ID add uses rs=5 -> exactly 1 cycle pc_we=0, ifid_we=0, idex_bubble=1, stall_cnt=1. Same case with wreg_ex=0 -> no stall.
- mult in ID at cycle t (MD_LATENCY=4) -> md_busy=1 for cycles t+1..t+4. mfhi in ID at t+1 stalls cycles t+1..t+4 and proceeds at t+5, with stall_cnt=4.
- DELAY_SLOT=0, branch_taken_id=1 with no hazard -> ifid_flush=1 for 1 cycle. Same stimulus combined with load_use -> ifid_flush=0, stall=1. DELAY_SLOT=1 -> ifid_flush never 1 outside reset.
- Reset asserted during MD_BUSY (md_cnt=2) -> next edge md_busy=0, state RUN. A hilo read then proceeds with no stall.
- CNT_W=4 with a continuous hazard for 20 cycles -> stall_cnt saturates at 15.
